// File: rtl/br_recov_ctrl.sv
// Branch misprediction recovery: picks the oldest mispredict by ROB age,
// pulses a flush, then holds a PC redirect until fetch accepts it.
module br_recov_ctrl #(
    parameter int XLEN  = 32,
    parameter int ROB_W = 5,
    parameter int N_BR  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_BR-1:0]        br_vld_i,
    input  logic [N_BR-1:0]        br_mispred_i,
    input  logic [N_BR*ROB_W-1:0]  br_tag_i,
    input  logic [N_BR*XLEN-1:0]   br_tgt_i,
    input  logic [ROB_W-1:0]       rob_head_i,
    output logic                   flush_o,
    output logic [ROB_W-1:0]       flush_tag_o,
    output logic                   redirect_vld_o,
    output logic [XLEN-1:0]        redirect_pc_o,
    input  logic                   redirect_rdy_i,
    output logic                   recov_busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ROB_W-1:0]   cur_tag_q, cur_tag_d;
    logic [XLEN-1:0]    cur_pc_q, cur_pc_d;

    logic               pick_vld;
    logic [ROB_W-1:0]   pick_tag;
    logic [ROB_W-1:0]   pick_age;
    logic [XLEN-1:0]    pick_pc;
    logic [ROB_W-1:0]   port_tag [N_BR];
    logic [ROB_W-1:0]   port_age [N_BR];
    logic [ROB_W-1:0]   cur_age;
    logic               older;

    // Strict less-than keeps the lower port on equal age.
    always_comb begin
        pick_vld = 1'b0;
        pick_tag = '0;
        pick_age = '0;
        pick_pc  = '0;
        for (int k = 0; k < N_BR; k++) begin
            port_tag[k] = br_tag_i[k*ROB_W +: ROB_W];
            port_age[k] = port_tag[k] - rob_head_i;
            if (br_vld_i[k] && br_mispred_i[k] &&
                (!pick_vld || port_age[k] < pick_age)) begin
                pick_vld = 1'b1;
                pick_tag = port_tag[k];
                pick_age = port_age[k];
                pick_pc  = br_tgt_i[k*XLEN +: XLEN];
            end
        end
    end

    assign cur_age = cur_tag_q - rob_head_i;
    assign older   = pick_vld && (pick_age < cur_age);

    always_comb begin
        state_d   = state_q;
        cur_tag_d = cur_tag_q;
        cur_pc_d  = cur_pc_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d   = FLUSH;
                    cur_tag_d = pick_tag;
                    cur_pc_d  = pick_pc;
                end
            end
            FLUSH: begin
                if (older) begin
                    cur_tag_d = pick_tag;
                    cur_pc_d  = pick_pc;
                end else begin
                    state_d = REDIR;
                end
            end
            REDIR: begin
                if (older) begin
                    state_d   = FLUSH;
                    cur_tag_d = pick_tag;
                    cur_pc_d  = pick_pc;
                end else if (redirect_rdy_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_tag_q <= '0;
            cur_pc_q  <= '0;
        end else begin
            state_q   <= state_d;
            cur_tag_q <= cur_tag_d;
            cur_pc_q  <= cur_pc_d;
        end
    end

    assign flush_o        = (state_q == FLUSH);
    assign redirect_vld_o = (state_q == REDIR);
    assign recov_busy_o   = (state_q != IDLE);
    assign flush_tag_o    = cur_tag_q;
    assign redirect_pc_o  = cur_pc_q;

endmodule

// File: tb/tb_br_recov_ctrl.sv
// Scoreboard bench for br_recov_ctrl: directed recovery scenarios followed
// by random traffic, checked against an age-based recovery model.
module tb_br_recov_ctrl;

    localparam int XLEN  = 32;
    localparam int ROB_W = 5;
    localparam int N_BR  = 2;
    localparam int DEPTH = 1 << ROB_W;

    logic                  clk;
    logic                  rst_n;
    logic [N_BR-1:0]       br_vld_i;
    logic [N_BR-1:0]       br_mispred_i;
    logic [N_BR*ROB_W-1:0] br_tag_i;
    logic [N_BR*XLEN-1:0]  br_tgt_i;
    logic [ROB_W-1:0]      rob_head_i;
    logic                  flush_o;
    logic [ROB_W-1:0]      flush_tag_o;
    logic                  redirect_vld_o;
    logic [XLEN-1:0]       redirect_pc_o;
    logic                  redirect_rdy_i;
    logic                  recov_busy_o;

    br_recov_ctrl #(.XLEN(XLEN), .ROB_W(ROB_W), .N_BR(N_BR)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .br_vld_i       (br_vld_i),
        .br_mispred_i   (br_mispred_i),
        .br_tag_i       (br_tag_i),
        .br_tgt_i       (br_tgt_i),
        .rob_head_i     (rob_head_i),
        .flush_o        (flush_o),
        .flush_tag_o    (flush_tag_o),
        .redirect_vld_o (redirect_vld_o),
        .redirect_pc_o  (redirect_pc_o),
        .redirect_rdy_i (redirect_rdy_i),
        .recov_busy_o   (recov_busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        f;
        bit [31:0] tag;
        bit        v;
        bit [31:0] pc;
        bit        b;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, req, $time);
        end
    endtask

    function automatic int age_of(input int tag, input int head);
        return (tag - head + DEPTH) % DEPTH;
    endfunction

    // Reference: a recovery is "none", "flushing" or "redirecting";
    // a strictly older mispredict restarts the flush.
    int        m_phase;
    int        m_tag;
    bit [31:0] m_pc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_tag   = 0;
            m_pc    = 0;
            q.delete();
        end else begin
            int  best_age;
            int  best_tag;
            bit  found;
            bit [31:0] best_pc;
            exp_t e;
            found    = 0;
            best_age = DEPTH;
            best_tag = 0;
            best_pc  = 0;
            for (int k = 0; k < N_BR; k++) begin
                int t;
                int a;
                t = int'(br_tag_i[k*ROB_W +: ROB_W]);
                a = age_of(t, int'(rob_head_i));
                if (br_vld_i[k] && br_mispred_i[k] && a < best_age) begin
                    found    = 1;
                    best_age = a;
                    best_tag = t;
                    best_pc  = br_tgt_i[k*XLEN +: XLEN];
                end
            end
            if (m_phase == 0) begin
                if (found) begin
                    m_phase = 1; m_tag = best_tag; m_pc = best_pc;
                end
            end else begin
                bit restart;
                restart = found &&
                    best_age < age_of(m_tag, int'(rob_head_i));
                if (restart) begin
                    m_phase = 1; m_tag = best_tag; m_pc = best_pc;
                end else if (m_phase == 1) begin
                    m_phase = 2;
                end else if (redirect_rdy_i) begin
                    m_phase = 0;
                end
            end
            e.f   = (m_phase == 1);
            e.v   = (m_phase == 2);
            e.b   = (m_phase != 0);
            e.tag = m_tag;
            e.pc  = m_pc;
            q.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (rst_n && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("flush_o", 32'(flush_o), 32'(e.f));
            chk("redirect_vld_o", 32'(redirect_vld_o), 32'(e.v));
            chk("recov_busy_o", 32'(recov_busy_o), 32'(e.b));
            if (e.f) chk("flush_tag_o", 32'(flush_tag_o), e.tag);
            if (e.v) chk("redirect_pc_o", redirect_pc_o, e.pc);
        end
    end

    task automatic cyc(input bit v0, input bit m0, input int t0,
                       input bit [31:0] g0, input bit v1, input bit m1,
                       input int t1, input bit [31:0] g1,
                       input int head, input bit rdy);
        br_vld_i       = {v1, v0};
        br_mispred_i   = {m1, m0};
        br_tag_i       = {ROB_W'(t1), ROB_W'(t0)};
        br_tgt_i       = {g1, g0};
        rob_head_i     = ROB_W'(head);
        redirect_rdy_i = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input int head);
        for (int i = 0; i < n; i++)
            cyc(0, 0, 0, 0, 0, 0, 0, 0, head, 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " flush_o"}, 32'(flush_o), 0);
        chk({tag, " flush_tag_o"}, 32'(flush_tag_o), 0);
        chk({tag, " redirect_vld_o"}, 32'(redirect_vld_o), 0);
        chk({tag, " redirect_pc_o"}, redirect_pc_o, 0);
        chk({tag, " recov_busy_o"}, 32'(recov_busy_o), 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        br_vld_i       = '0;
        br_mispred_i   = '0;
        br_tag_i       = '0;
        br_tgt_i       = '0;
        rob_head_i     = '0;
        redirect_rdy_i = 1'b0;
        #1;
        chk_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(2, 0);

        // single mispredict
        cyc(1, 1, 5, 32'h100, 0, 0, 0, 0, 0, 1);
        idle(4, 0);

        // same-cycle selection, then head moved
        cyc(1, 1, 9, 32'hA00, 1, 1, 3, 32'hB00, 2, 1);
        idle(4, 2);
        cyc(1, 1, 9, 32'hA04, 1, 1, 3, 32'hB04, 4, 1);
        idle(4, 4);

        // wrap-around
        cyc(1, 1, 1, 32'hC00, 1, 1, 31, 32'hD00, 30, 1);
        idle(4, 30);

        // equal age: lower port wins
        cyc(1, 1, 7, 32'hE00, 1, 1, 7, 32'hF00, 0, 1);
        idle(4, 0);

        // preemption in REDIRECT, then younger ignored
        cyc(1, 1, 10, 32'h1000, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 6, 32'h600, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 12, 32'h1200, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(3, 0);

        // backpressure
        cyc(0, 0, 0, 0, 1, 1, 20, 32'h2000, 0, 0);
        for (int i = 0; i < 6; i++)
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3, 0);

        // reset while redirecting
        cyc(1, 1, 14, 32'h1400, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("pre-reset redirect_vld_o", 32'(redirect_vld_o), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("async reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(5, 0);

        // random traffic
        begin
            int head;
            head = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(7) == 0) head = $urandom_range(DEPTH - 1);
                cyc($urandom_range(1), $urandom_range(3) == 0,
                    $urandom_range(DEPTH - 1), $urandom,
                    $urandom_range(1), $urandom_range(3) == 0,
                    $urandom_range(DEPTH - 1), $urandom,
                    head, $urandom_range(1));
            end
        end
        idle(6, 0);
        @(negedge clk);
        #1;
        chk("scoreboard drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
